pmp_checker: RTL and testbench

PMP_CHECKER -- requirements
Module: pmp_checker

---
 rtl/pmp_checker_pkg.sv | 58 +++++
 rtl/pmp_checker_match.sv | 72 +++++++
 rtl/pmp_checker.sv | 163 ++++++++++++++++
 tb/tb_pmp_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_checker_pkg.sv
// ----------------------------------------------------------------------------
// pmp_checker_pkg -- shared PMP types, encodings and CSR addresses.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pmp_checker_pkg;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam logic [1:0] KIND_READ  = 2'd0;
  localparam logic [1:0] KIND_WRITE = 2'd1;
  localparam logic [1:0] KIND_EXEC  = 2'd2;

  localparam logic [1:0] U_MODE = 2'd0;
  localparam logic [1:0] S_MODE = 2'd1;
  localparam logic [1:0] M_MODE = 2'd3;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  typedef struct packed {
    logic        cwren;
    logic [11:0] cwaddr;
    logic [31:0] cwdata;
    logic        crden;
    logic [11:0] craddr;
  } csr_in_t;

  typedef struct packed {
    logic [31:0] crdata;
    logic        cready;
  } csr_out_t;

  // Reserved bits read zero, W without R is dropped, NA4 collapses to OFF when coarse.
  function automatic pmp_cfg_t legalize_cfg(input logic [7:0] raw, input logic na4_ok);
    pmp_cfg_t c;
    c      = pmp_cfg_t'(raw);
    c.rsvd = 2'b00;
    if (!c.r && c.w) c.w = 1'b0;
    if (!na4_ok && c.a == A_NA4) c.a = A_OFF;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pmp_checker_match.sv
// ----------------------------------------------------------------------------
// pmp_match -- per-port region match and lowest-index permission decision. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pmp_match import pmp_checker_pkg::*; #(
  parameter int REGIONS = 16
) (
  input  pmp_cfg_t [REGIONS-1:0]       cfg,
  input  logic     [REGIONS-1:0][31:0] pmpaddr,
  input  logic                         req_valid,
  input  logic     [31:0]              req_addr,
  input  logic     [1:0]               req_kind,
  input  logic     [1:0]               req_mode,
  output logic                         chk_error
);

  logic [31:0]        word;
  logic [REGIONS-1:0] hit;
  pmp_cfg_t           sel;
  logic               any_hit;
  logic               perm;
  logic               allow;
  logic               unused_bits;

  assign word = {2'b00, req_addr[31:2]};

  for (genvar i = 0; i < REGIONS; i++) begin : g_region
    logic [31:0] lower;
    logic [31:0] care;
    if (i == 0) begin : g_base
      assign lower = '0;
    end else begin : g_prev
      assign lower = pmpaddr[i-1];
    end
    // NAPOT: trailing ones plus the next bit are don't-care
    assign care   = ~(pmpaddr[i] ^ (pmpaddr[i] + 32'd1));
    assign hit[i] = (cfg[i].a == A_TOR)   ? ((word >= lower) && (word < pmpaddr[i])) :
                    (cfg[i].a == A_NA4)   ? (word == pmpaddr[i]) :
                    (cfg[i].a == A_NAPOT) ? (((word ^ pmpaddr[i]) & care) == 32'd0) :
                                            1'b0;
  end

  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sel     = cfg[i];
      end
    end
  end

  always_comb begin
    perm = 1'b0;
    case (req_kind)
      KIND_READ:  perm = sel.r;
      KIND_WRITE: perm = sel.w;
      KIND_EXEC:  perm = sel.x;
      default:    perm = 1'b0;
    endcase
  end

  assign allow     = any_hit ? (perm || (req_mode == M_MODE && !sel.l)) : (req_mode == M_MODE);
  assign chk_error = req_valid && !allow;

  assign unused_bits = ^{req_addr[1:0], sel.rsvd, sel.a};

endmodule

`default_nettype wire

// File: rtl/pmp_checker.sv
// ----------------------------------------------------------------------------
// pmp_checker -- PMP CSR file, multi-port checks, fault capture. PMP_PIPE_EN
// registers results by one cycle.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pmp_checker import pmp_checker_pkg::*; #(
  parameter int REGIONS = 16,
  parameter int PORTS   = 2,
  parameter int GRAN    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  csr_in_t               csr_in,
  output csr_out_t              csr_out,
  input  logic [PORTS-1:0]      req_valid,
  input  logic [PORTS-1:0][31:0] req_addr,
  input  logic [PORTS-1:0][1:0] req_kind,
  input  logic [PORTS-1:0][1:0] req_mode,
  output logic [PORTS-1:0]      chk_valid,
  output logic [PORTS-1:0]      chk_error,
  output logic                  fault_valid,
  output logic [31:0]           fault_addr,
  output logic [1:0]            fault_port,
  output logic [1:0]            fault_kind,
  input  logic                  fault_clear,
  output logic [7:0]            fault_count
);

  localparam int          CFG_REGS   = REGIONS / 4;
  localparam logic [31:0] NAPOT_ONES = ((32'd1 << GRAN) - 32'd1) >> 1;
  localparam logic        NA4_OK     = (GRAN == 0);

  pmp_cfg_t [REGIONS-1:0]       pmpcfg;
  logic     [REGIONS-1:0][31:0] pmpaddr;
  logic     [REGIONS-1:0][31:0] pmpaddr_eff;
  logic     [REGIONS-1:0]       addr_locked;
  logic     [PORTS-1:0]         err;

  for (genvar i = 0; i < REGIONS; i++) begin : g_entry
    assign pmpaddr_eff[i] = (pmpcfg[i].a == A_NAPOT) ? (pmpaddr[i] | NAPOT_ONES) : pmpaddr[i];
    if (i == REGIONS - 1) begin : g_last
      assign addr_locked[i] = pmpcfg[i].l;
    end else begin : g_mid
      // A locked TOR entry above also freezes this entry's address as its base
      assign addr_locked[i] = pmpcfg[i].l || (pmpcfg[i+1].l && pmpcfg[i+1].a == A_TOR);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pmpcfg  <= '0;
      pmpaddr <= '0;
    end else if (csr_in.cwren) begin
      for (int i = 0; i < REGIONS; i++) begin
        if (csr_in.cwaddr == CSR_PMPCFG0 + 12'(i / 4) && !pmpcfg[i].l)
          pmpcfg[i] <= legalize_cfg(csr_in.cwdata[8*(i%4) +: 8], NA4_OK);
        if (csr_in.cwaddr == CSR_PMPADDR0 + 12'(i) && !addr_locked[i])
          pmpaddr[i] <= csr_in.cwdata;
      end
    end
  end

  always_comb begin
    csr_out = '0;
    if (csr_in.crden) begin
      for (int j = 0; j < CFG_REGS; j++) begin
        if (csr_in.craddr == CSR_PMPCFG0 + 12'(j)) begin
          csr_out.crdata = pmpcfg[4*j +: 4];
          csr_out.cready = 1'b1;
        end
      end
      for (int i = 0; i < REGIONS; i++) begin
        if (csr_in.craddr == CSR_PMPADDR0 + 12'(i)) begin
          csr_out.crdata = pmpaddr_eff[i];
          csr_out.cready = 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    pmp_match #(.REGIONS(REGIONS)) u_match (
      .cfg       (pmpcfg),
      .pmpaddr   (pmpaddr_eff),
      .req_valid (req_valid[p]),
      .req_addr  (req_addr[p]),
      .req_kind  (req_kind[p]),
      .req_mode  (req_mode[p]),
      .chk_error (err[p])
    );
  end

`ifdef PMP_PIPE_EN
  logic [PORTS-1:0] valid_q;
  logic [PORTS-1:0] error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      error_q <= '0;
    end else begin
      valid_q <= req_valid;
      error_q <= err;
    end
  end

  assign chk_valid = valid_q;
  assign chk_error = error_q;
`else
  assign chk_valid = reset ? '0 : req_valid;
  assign chk_error = reset ? '0 : err;
`endif

  logic        first_found;
  logic [1:0]  first_port;
  logic [31:0] first_addr;
  logic [1:0]  first_kind;
  logic [2:0]  n_err;
  logic [8:0]  count_sum;

  always_comb begin
    first_found = 1'b0;
    first_port  = '0;
    first_addr  = '0;
    first_kind  = '0;
    n_err       = '0;
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (err[p]) begin
        first_found = 1'b1;
        first_port  = 2'(p);
        first_addr  = req_addr[p];
        first_kind  = req_kind[p];
      end
    end
    for (int p = 0; p < PORTS; p++) n_err = n_err + 3'(err[p]);
  end

  assign count_sum = {1'b0, fault_count} + 9'(n_err);

  always_ff @(posedge clock) begin
    if (reset) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_port  <= '0;
      fault_kind  <= '0;
      fault_count <= '0;
    end else begin
      if (first_found && (!fault_valid || fault_clear)) begin
        fault_valid <= 1'b1;
        fault_addr  <= first_addr;
        fault_port  <= first_port;
        fault_kind  <= first_kind;
      end else if (fault_clear) begin
        fault_valid <= 1'b0;
      end
      fault_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pmp_checker.sv
// ----------------------------------------------------------------------------
// tb_pmp_checker -- directed self-checking bench for pmp_checker.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pmp_checker;
  import pmp_checker_pkg::*;

`ifdef PMP_PIPE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  csr_in_t          csr_in = '0;
  csr_out_t         csr_out;
  logic [1:0]       req_valid = '0;
  logic [1:0][31:0] req_addr = '0;
  logic [1:0][1:0]  req_kind = '0;
  logic [1:0][1:0]  req_mode = '0;
  logic [1:0]       chk_valid, chk_error;
  logic             fault_valid;
  logic [31:0]      fault_addr;
  logic [1:0]       fault_port, fault_kind;
  logic             fault_clear = 1'b0;
  logic [7:0]       fault_count;

  int checks = 0;
  int passes = 0;

  logic [31:0] rd;
  logic        rdy;
  logic [1:0]  cv, ce, early;
  logic [1:0]  early_exp;

  pmp_checker dut (
    .clock(clock), .reset(reset), .csr_in(csr_in), .csr_out(csr_out),
    .req_valid(req_valid), .req_addr(req_addr), .req_kind(req_kind), .req_mode(req_mode),
    .chk_valid(chk_valid), .chk_error(chk_error), .fault_valid(fault_valid),
    .fault_addr(fault_addr), .fault_port(fault_port), .fault_kind(fault_kind),
    .fault_clear(fault_clear), .fault_count(fault_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req_valid = '0; fault_clear = 1'b0; csr_in = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    csr_in.cwren = 1'b1; csr_in.cwaddr = a; csr_in.cwdata = d;
    @(negedge clock);
    csr_in.cwren = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic r);
    csr_in.crden = 1'b1; csr_in.craddr = a;
    #1;
    d = csr_out.crdata; r = csr_out.cready;
    csr_in.crden = 1'b0;
  endtask

  // Drives one request cycle; returns result at the configured latency plus the request-cycle valid.
  task automatic issue(input logic [1:0] v,
                       input logic [31:0] a0, input logic [1:0] k0, input logic [1:0] m0,
                       input logic [31:0] a1, input logic [1:0] k1, input logic [1:0] m1,
                       input logic clr, output logic [1:0] o_cv, output logic [1:0] o_ce,
                       output logic [1:0] o_early);
    @(negedge clock);
    req_valid = v; req_addr[0] = a0; req_kind[0] = k0; req_mode[0] = m0;
    req_addr[1] = a1; req_kind[1] = k1; req_mode[1] = m1; fault_clear = clr;
    #1;
    o_early = chk_valid;
    o_cv = chk_valid; o_ce = chk_error;
    @(posedge clock);
    #1;
    if (LAT == 1) begin o_cv = chk_valid; o_ce = chk_error; end
    @(negedge clock);
    req_valid = '0; fault_clear = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b01; req_addr[0] = 32'h100; req_kind[0] = KIND_READ; req_mode[0] = U_MODE;
    @(posedge clock); @(posedge clock); #1;
    checks++; if (chk_valid !== 2'b00) $display("FAIL reset_chk_valid: got %b exp 00", chk_valid); else passes++;
    checks++; if (fault_valid !== 1'b0) $display("FAIL reset_fault_valid: got %b exp 0", fault_valid); else passes++;
    checks++; if (fault_count !== 8'd0) $display("FAIL reset_fault_count: got %0d exp 0", fault_count); else passes++;
    @(negedge clock);
    reset = 1'b0; req_valid = '0;
    csr_read(12'h3A0, rd, rdy);
    checks++; if (rd !== 32'h0 || rdy !== 1'b1) $display("FAIL reset_cfg_rd: got %h/%b exp 0/1", rd, rdy); else passes++;
    csr_read(12'h3B5, rd, rdy);
    checks++; if (rd !== 32'h0) $display("FAIL reset_addr_rd: got %h exp 0", rd); else passes++;
  endtask

  task automatic test_napot();
    do_reset();
    csr_write(12'h3A0, 32'h19);
    csr_write(12'h3B0, 32'h1FF);
    csr_read(12'h3A0, rd, rdy);
    checks++; if (rd !== 32'h19) $display("FAIL napot_cfg_rd: got %h exp 19", rd); else passes++;
    issue(2'b01, 32'h0FFC, KIND_READ, U_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (cv[0] !== 1'b1 || ce[0] !== 1'b0) $display("FAIL napot_inside: got v%b e%b exp v1 e0", cv[0], ce[0]); else passes++;
    checks++; if (fault_valid !== 1'b0) $display("FAIL napot_no_fault: got %b exp 0", fault_valid); else passes++;
    issue(2'b01, 32'h1000, KIND_READ, U_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    early_exp = (LAT == 0) ? 2'b01 : 2'b00;
    checks++; if (early !== early_exp) $display("FAIL napot_latency: got %b exp %b", early, early_exp); else passes++;
    checks++; if (cv[0] !== 1'b1 || ce[0] !== 1'b1) $display("FAIL napot_outside: got v%b e%b exp v1 e1", cv[0], ce[0]); else passes++;
    checks++; if (fault_valid !== 1'b1 || fault_addr !== 32'h1000 || fault_kind !== KIND_READ)
      $display("FAIL napot_fault: got v%b a%h k%0d exp v1 a00001000 k0", fault_valid, fault_addr, fault_kind); else passes++;
    issue(2'b01, 32'h1000, KIND_READ, M_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (ce[0] !== 1'b0) $display("FAIL napot_mmode_nomatch: got e%b exp e0", ce[0]); else passes++;
    checks++; if (fault_count !== 8'd1) $display("FAIL napot_count: got %0d exp 1", fault_count); else passes++;
  endtask

  task automatic test_tor_priority();
    do_reset();
    csr_write(12'h3A0, 32'h00001F08);
    csr_write(12'h3B0, 32'h400);
    csr_write(12'h3B1, 32'h1FFFFFFF);
    issue(2'b01, 32'h800, KIND_READ, U_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (ce[0] !== 1'b1) $display("FAIL tor_region0_wins: got e%b exp e1", ce[0]); else passes++;
    issue(2'b01, 32'h2000, KIND_READ, U_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (ce[0] !== 1'b0) $display("FAIL tor_region1_allow: got e%b exp e0", ce[0]); else passes++;
    issue(2'b10, 32'h0, KIND_READ, U_MODE, 32'hFFC, KIND_WRITE, S_MODE, 1'b0, cv, ce, early);
    checks++; if (cv !== 2'b10 || ce !== 2'b10) $display("FAIL tor_top_edge: got v%b e%b exp v10 e10", cv, ce); else passes++;
    issue(2'b01, 32'h1000, KIND_EXEC, S_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (ce[0] !== 1'b0) $display("FAIL tor_upper_excl: got e%b exp e0", ce[0]); else passes++;
    checks++; if (fault_addr !== 32'h800 || fault_port !== 2'd0)
      $display("FAIL tor_first_fault: got a%h p%0d exp a00000800 p0", fault_addr, fault_port); else passes++;
  endtask

  task automatic test_lock();
    do_reset();
    csr_write(12'h3B0, 32'h1FF);
    csr_write(12'h3A0, 32'h99);
    csr_write(12'h3B0, 32'h123);
    csr_read(12'h3B0, rd, rdy);
    checks++; if (rd !== 32'h1FF) $display("FAIL lock_addr_ignored: got %h exp 1ff", rd); else passes++;
    csr_write(12'h3A0, 32'h88000000);
    csr_read(12'h3A0, rd, rdy);
    checks++; if (rd !== 32'h88000099) $display("FAIL lock_cfg_ignored: got %h exp 88000099", rd); else passes++;
    csr_write(12'h3B2, 32'h55);
    csr_write(12'h3B1, 32'h77);
    csr_read(12'h3B2, rd, rdy);
    checks++; if (rd !== 32'h0) $display("FAIL lock_tor_base: got %h exp 0", rd); else passes++;
    csr_read(12'h3B1, rd, rdy);
    checks++; if (rd !== 32'h77) $display("FAIL lock_unlocked_addr: got %h exp 77", rd); else passes++;
    issue(2'b01, 32'h100, KIND_WRITE, M_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (ce[0] !== 1'b1) $display("FAIL lock_mmode_write: got e%b exp e1", ce[0]); else passes++;
    issue(2'b01, 32'h100, KIND_READ, M_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (ce[0] !== 1'b0) $display("FAIL lock_mmode_read: got e%b exp e0", ce[0]); else passes++;
  endtask

  task automatic test_csr_legalize();
    do_reset();
    csr_write(12'h3A0, 32'h00726603);
    csr_read(12'h3A0, rd, rdy);
    checks++; if (rd !== 32'h00100403) $display("FAIL legal_cfg: got %h exp 00100403", rd); else passes++;
    csr_write(12'h3BF, 32'hDEADBEEF);
    csr_read(12'h3BF, rd, rdy);
    checks++; if (rd !== 32'hDEADBEEF || rdy !== 1'b1) $display("FAIL legal_addr15: got %h/%b exp deadbeef/1", rd, rdy); else passes++;
    csr_read(12'h3C0, rd, rdy);
    checks++; if (rd !== 32'h0 || rdy !== 1'b0) $display("FAIL legal_unimpl_addr: got %h/%b exp 0/0", rd, rdy); else passes++;
    csr_read(12'h3A4, rd, rdy);
    checks++; if (rd !== 32'h0 || rdy !== 1'b0) $display("FAIL legal_unimpl_cfg: got %h/%b exp 0/0", rd, rdy); else passes++;
  endtask

  task automatic test_multi_port();
    do_reset();
    issue(2'b11, 32'h100, KIND_READ, U_MODE, 32'h200, KIND_WRITE, U_MODE, 1'b0, cv, ce, early);
    checks++; if (ce !== 2'b11) $display("FAIL multi_both_err: got e%b exp e11", ce); else passes++;
    checks++; if (fault_port !== 2'd0 || fault_addr !== 32'h100 || fault_count !== 8'd2)
      $display("FAIL multi_tie: got p%0d a%h c%0d exp p0 a00000100 c2", fault_port, fault_addr, fault_count); else passes++;
    issue(2'b10, 32'h0, KIND_READ, U_MODE, 32'h300, KIND_EXEC, U_MODE, 1'b1, cv, ce, early);
    checks++; if (fault_valid !== 1'b1 || fault_port !== 2'd1 || fault_addr !== 32'h300 || fault_kind !== KIND_EXEC || fault_count !== 8'd3)
      $display("FAIL multi_clear_new: got v%b p%0d a%h k%0d c%0d exp v1 p1 a00000300 k2 c3",
               fault_valid, fault_port, fault_addr, fault_kind, fault_count); else passes++;
    issue(2'b01, 32'h400, KIND_READ, S_MODE, 32'h0, KIND_READ, U_MODE, 1'b0, cv, ce, early);
    checks++; if (fault_port !== 2'd1 || fault_addr !== 32'h300 || fault_count !== 8'd4)
      $display("FAIL multi_hold: got p%0d a%h c%0d exp p1 a00000300 c4", fault_port, fault_addr, fault_count); else passes++;
    issue(2'b00, 32'h0, KIND_READ, U_MODE, 32'h0, KIND_READ, U_MODE, 1'b1, cv, ce, early);
    checks++; if (fault_valid !== 1'b0 || fault_count !== 8'd4 || cv !== 2'b00)
      $display("FAIL multi_clear_only: got v%b c%0d cv%b exp v0 c4 cv00", fault_valid, fault_count, cv); else passes++;
  endtask

  task automatic test_reset_clear();
    do_reset();
    csr_write(12'h3A0, 32'h19);
    @(negedge clock);
    req_valid = 2'b11; req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    req_kind = '0; req_mode = {U_MODE, U_MODE};
    repeat (128) @(posedge clock);
    #1;
    checks++; if (fault_count !== 8'd255) $display("FAIL sat_count: got %0d exp 255", fault_count); else passes++;
    @(negedge clock);
    req_valid = '0; fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    checks++; if (fault_valid !== 1'b0 || fault_count !== 8'd255)
      $display("FAIL sat_clear_keeps: got v%b c%0d exp v0 c255", fault_valid, fault_count); else passes++;
    do_reset();
    csr_write(12'h3A0, 32'h19);
    @(negedge clock);
    req_valid = 2'b11;
    repeat (100) @(posedge clock);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    checks++; if (fault_count !== 8'd200 || fault_valid !== 1'b1)
      $display("FAIL pre_reset_state: got c%0d v%b exp c200 v1", fault_count, fault_valid); else passes++;
    reset = 1'b1; req_valid = 2'b11;
    #1;
    checks++; if (chk_valid !== 2'b00) $display("FAIL midreset_comb: got %b exp 00", chk_valid); else passes++;
    @(posedge clock);
    #1;
    checks++; if (chk_valid !== 2'b00 || fault_valid !== 1'b0 || fault_count !== 8'd0)
      $display("FAIL midreset_clear: got cv%b v%b c%0d exp cv00 v0 c0", chk_valid, fault_valid, fault_count); else passes++;
    @(negedge clock);
    reset = 1'b0; req_valid = '0;
    csr_read(12'h3A0, rd, rdy);
    checks++; if (rd !== 32'h0) $display("FAIL midreset_cfg: got %h exp 0", rd); else passes++;
    @(posedge clock);
    #1;
    checks++; if (chk_valid !== 2'b00 || fault_valid !== 1'b0)
      $display("FAIL midreset_discard: got cv%b v%b exp cv00 v0", chk_valid, fault_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_napot();
    test_tor_priority();
    test_lock();
    test_csr_legalize();
    test_multi_port();
    test_reset_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
